liteeth_sram_fifo_ctrl: RTL and testbench

LITEETH_SRAM_FIFO_CTRL -- requirements
Module: liteeth_sram_fifo_ctrl

---
 rtl/liteeth_sram_fifo_ctrl.sv | 110 +++++++++++
 tb/tb_liteeth_sram_fifo_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/liteeth_sram_fifo_ctrl.sv
// SRAM-backed stream FIFO: DEPTH words in an external 1RW (write) + 1R (read) SRAM plus a 2-entry output stage.
// Define LITEETH_SRAM_FIFO_LEVEL_EN to add the registered occupancy port `level`.
module liteeth_sram_fifo_ctrl #(
    parameter int WIDTH      = 12,
    parameter int DEPTH      = 128,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  sram_rw0_ce,
    output logic                  sram_rw0_we,
    output logic [ADDR_WIDTH-1:0] sram_rw0_addr,
    output logic [WIDTH-1:0]      sram_rw0_wd,
    output logic                  sram_r0_ce,
    output logic [ADDR_WIDTH-1:0] sram_r0_addr,
    input  logic [WIDTH-1:0]      sram_r0_rd
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
    ,
    output logic [7:0]            level
`endif
);

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   sram_cnt;
    logic [1:0]            out_cnt;
    logic                  inflight;
    logic [WIDTH-1:0]      stg0, stg1;
    logic                  accept, pop, issue, capture;
    logic [2:0]            occ;

    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == ADDR_WIDTH'(DEPTH - 1)) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    assign in_ready  = (sram_cnt != (ADDR_WIDTH+1)'(DEPTH)) && !flush && rst_n;
    assign accept    = in_valid && in_ready;
    assign out_valid = (out_cnt != 2'd0) && !flush;
    assign pop       = out_valid && out_ready;
    assign out_data  = stg0;

    // Words owned by the output side (held + in flight); a pop this cycle frees a slot.
    assign occ     = {1'b0, out_cnt} + {2'b0, inflight};
    assign issue   = (sram_cnt != '0) && !flush && (occ < (3'd2 + {2'b0, pop}));
    // Read port output is only meaningful the cycle after an issue.
    assign capture = inflight && !flush;

    assign sram_rw0_ce   = accept;
    assign sram_rw0_we   = accept;
    assign sram_rw0_addr = accept ? wr_ptr : '0;
    assign sram_rw0_wd   = accept ? in_data : '0;
    assign sram_r0_ce    = issue;
    assign sram_r0_addr  = issue ? rd_ptr : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sram_cnt <= '0;
            out_cnt  <= '0;
            inflight <= 1'b0;
            stg0     <= '0;
            stg1     <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sram_cnt <= '0;
            out_cnt  <= '0;
            inflight <= 1'b0;
        end else begin
            if (accept) wr_ptr <= ptr_inc(wr_ptr);
            if (issue)  rd_ptr <= ptr_inc(rd_ptr);
            sram_cnt <= sram_cnt + {{ADDR_WIDTH{1'b0}}, accept} - {{ADDR_WIDTH{1'b0}}, issue};
            inflight <= issue;
            out_cnt  <= out_cnt + {1'b0, capture} - {1'b0, pop};
            case ({capture, pop})
                2'b10: begin
                    if (out_cnt == 2'd0) stg0 <= sram_r0_rd;
                    else                 stg1 <= sram_r0_rd;
                end
                2'b01: stg0 <= stg1;
                2'b11: begin
                    if (out_cnt == 2'd1) begin
                        stg0 <= sram_r0_rd;
                    end else begin
                        stg0 <= stg1;
                        stg1 <= sram_r0_rd;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
    // Total occupancy only moves on accept/pop; issue and capture shuffle words internally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     level <= '0;
        else if (flush) level <= '0;
        else            level <= level + {7'd0, accept} - {7'd0, pop};
    end
`endif

endmodule

// File: tb/tb_liteeth_sram_fifo_ctrl.sv
// Randomised scoreboard bench for liteeth_sram_fifo_ctrl with a behavioural SRAM and a queue reference model.
module tb_liteeth_sram_fifo_ctrl;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        flush = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [11:0] in_data = 0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [11:0] out_data;
    logic        sram_rw0_ce, sram_rw0_we;
    logic [6:0]  sram_rw0_addr;
    logic [11:0] sram_rw0_wd;
    logic        sram_r0_ce;
    logic [6:0]  sram_r0_addr;
    logic [11:0] sram_r0_rd = 0;
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
    logic [7:0]  level;
`endif

    liteeth_sram_fifo_ctrl dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sram_rw0_ce(sram_rw0_ce), .sram_rw0_we(sram_rw0_we),
        .sram_rw0_addr(sram_rw0_addr), .sram_rw0_wd(sram_rw0_wd),
        .sram_r0_ce(sram_r0_ce), .sram_r0_addr(sram_r0_addr), .sram_r0_rd(sram_r0_rd)
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
        , .level(level)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pop_cnt = 0;
    logic [11:0] last_pop = 0;
    logic [11:0] q[$];
    int m_wp = 0, m_rp = 0;
    logic [11:0] mem [128];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: garbage on the read port whenever no read was issued
    always @(posedge clk) begin
        if (sram_rw0_ce && sram_rw0_we) mem[sram_rw0_addr] <= sram_rw0_wd;
        sram_r0_rd <= sram_r0_ce ? mem[sram_r0_addr] : 12'($urandom);
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_wp = 0;
            m_rp = 0;
        end else begin
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
            chk("level", 32'(level), 32'(q.size()));
`endif
            if (!sram_rw0_ce)
                chk("rw0_idle", {12'd0, sram_rw0_we, sram_rw0_addr, sram_rw0_wd}, 32'd0);
            if (!sram_r0_ce)
                chk("r0_idle", 32'(sram_r0_addr), 32'd0);
            if (sram_rw0_ce && sram_r0_ce)
                chk("rw_collide", 32'(sram_rw0_addr == sram_r0_addr), 32'd0);
            if (flush) begin
                q.delete();
                m_wp = 0;
                m_rp = 0;
            end else begin
                if (sram_r0_ce) begin
                    chk("r0_addr", 32'(sram_r0_addr), 32'(m_rp % 128));
                    m_rp++;
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("pop_nonempty", 32'd1, 32'd0);
                    end else begin
                        chk("out_data", 32'(out_data), 32'(q.pop_front()));
                    end
                    last_pop = out_data;
                    pop_cnt++;
                end
                if (in_valid && in_ready) begin
                    chk("rw0_write", {sram_rw0_ce, sram_rw0_we, sram_rw0_addr, sram_rw0_wd},
                        {1'b1, 1'b1, 7'(m_wp % 128), in_data});
                    m_wp++;
                    q.push_back(in_data);
                end
            end
        end
    end

    task automatic push(input logic [11:0] d);
        int t = 0;
        in_valid = 1;
        in_data = d;
        @(negedge clk);
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) chk("push_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", 32'(t >= 3000), 32'd0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, t0, sent, t;
        bit did_rst;

        // reset state
        #13;
        chk("rst_outs", {in_ready, out_valid, sram_rw0_ce, sram_rw0_we, sram_r0_ce}, 32'd0);
        @(posedge clk); #3 rst_n = 1;
        @(negedge clk);
        chk("rst_release_ready", 32'(in_ready), 32'd1);
        chk("rst_release_valid", 32'(out_valid), 32'd0);

        // single word latency
        @(posedge clk); #1;
        in_valid = 1; in_data = 12'hABC; out_ready = 1;
        @(negedge clk); chk("lat_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1 in_valid = 0;
        @(negedge clk);
        chk("lat_r0_ce", 32'(sram_r0_ce), 32'd1);
        chk("lat_ov_e1", 32'(out_valid), 32'd0);
        @(negedge clk); chk("lat_ov_e1b", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_ov_e2", 32'(out_valid), 32'd1);
        chk("lat_data", 32'(out_data), 32'hABC);
        wait_drain();

        // fill to capacity 130 with no drain, then drain in order
        @(posedge clk); #1 out_ready = 0;
        base = pop_cnt;
        for (int i = 0; i < 130; i++) push(12'(i));
        @(negedge clk);
        chk("full_ready", 32'(in_ready), 32'd0);
        chk("full_qsize", 32'(q.size()), 32'd130);
        chk("full_ov", 32'(out_valid), 32'd1);
        repeat (3) @(negedge clk);
        chk("full_ready_hold", 32'(in_ready), 32'd0);
        @(posedge clk); #1 out_ready = 1;
        wait_drain();
        chk("full_popped", 32'(pop_cnt - base), 32'd130);
        chk("full_last", 32'(last_pop), 32'd129);

        // sustained throughput, 300 words, wrap past 127
        @(posedge clk); #1;
        base = pop_cnt;
        t0 = cyc;
        for (int i = 0; i < 300; i++) push(12'(i + 1000));
        chk("thru_in_cycles", 32'(cyc - t0), 32'd300);
        chk("thru_pops", 32'(pop_cnt - base >= 297), 32'd1);
        wait_drain();
        chk("thru_last", 32'(last_pop), 32'(1299));

        // flush with words queued and a read in flight
        @(posedge clk); #1 out_ready = 0;
        for (int i = 0; i < 50; i++) push(12'($urandom));
        repeat (4) @(posedge clk);
        #1 out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        flush = 1;
        @(negedge clk);
        chk("flush_ov", 32'(out_valid), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1 flush = 0;
        @(negedge clk);
        chk("post_flush_ov", 32'(out_valid), 32'd0);
`ifdef LITEETH_SRAM_FIFO_LEVEL_EN
        chk("post_flush_level", 32'(level), 32'd0);
`endif
        @(posedge clk); #1;
        base = pop_cnt;
        out_ready = 1;
        push(12'h123);
        wait_drain();
        chk("flush_first", 32'(last_pop), 32'h123);
        chk("flush_one", 32'(pop_cnt - base), 32'd1);

        // random traffic with back-pressure and a mid-stream reset
        sent = 0; t = 0; did_rst = 0;
        while (sent < 1000 && t < 20000) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data = 12'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (sent == 500 && !did_rst) begin
                did_rst = 1;
                in_valid = 0;
                #2 rst_n = 0;
                #1;
                chk("midrst_outs", {in_ready, out_valid, sram_rw0_ce, sram_r0_ce}, 32'd0);
                @(posedge clk);
                @(posedge clk);
                #3 rst_n = 1;
                @(negedge clk);
                chk("midrst_ready", 32'(in_ready), 32'd1);
                chk("midrst_empty", 32'(out_valid), 32'd0);
            end
            @(posedge clk); #1;
            t++;
        end
        chk("rand_timeout", 32'(t >= 20000), 32'd0);
        in_valid = 0;
        out_ready = 1;
        wait_drain();
        repeat (4) @(negedge clk);
        chk("end_ov", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
